// File: rtl/a2d_rr_master_if.sv
// SPI bus between the a2d_rr_master and the ADC128S converter.
// The master drives select, clock and command; the converter returns MISO.
interface a2d_rr_master_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/a2d_rr_master.sv
// Round-robin SPI master for the ADC128S: converts channels 0,2,5,7 per round.
// Define A2D_CONTINUOUS_EN to keep converting rounds back to back after the first strt.
module a2d_rr_master #(
    parameter int SCLK_DIV   = 32,
    parameter int GAP_CYCLES = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            strt,
    a2d_rr_master_if.master spi,
    output logic [11:0]     batt,
    output logic [11:0]     IR_rght,
    output logic [11:0]     IR_lft,
    output logic [11:0]     IR_cntr,
    output logic            busy,
    output logic            cnv_cmplt
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_TX1  = 3'd1;
    localparam logic [2:0] S_GAP1 = 3'd2;
    localparam logic [2:0] S_TX2  = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_GAP2 = 3'd5;

    localparam logic [15:0] HALF_LAST  = 16'(SCLK_DIV / 2 - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);
    localparam logic [5:0]  LAST_PHASE = 6'd33;

    logic [2:0]  r_state;
    logic [1:0]  r_idx;
    logic [15:0] r_tick;
    logic [5:0]  r_phase;
    logic [15:0] r_txShift;
    logic [11:0] r_rx;
    logic        r_ssN;
    logic        r_sclk;
    logic        r_mosi;
    logic        r_busy;
    logic        r_cnvCmplt;
    logic [11:0] r_batt;
    logic [11:0] r_irRght;
    logic [11:0] r_irLft;
    logic [11:0] r_irCntr;

    logic [1:0]  w_txIdx;
    logic [15:0] w_cmd;
    logic [5:0]  w_nextPhase;
    logic        w_tickDone;
    logic        w_gapDone;

    function automatic logic [15:0] cmdWord(input logic [1:0] idx);
        logic [2:0] ch;
        case (idx)
            2'd0:    ch = 3'b000;
            2'd1:    ch = 3'b010;
            2'd2:    ch = 3'b101;
            default: ch = 3'b111;
        endcase
        return {2'b00, ch, 11'h000};
    endfunction

    // A round always begins at index 0, so IDLE launches with that command
    assign w_txIdx     = (r_state == S_IDLE) ? 2'd0 : r_idx;
    assign w_cmd       = cmdWord(w_txIdx);
    assign w_nextPhase = r_phase + 6'd1;
    assign w_tickDone  = (r_tick == HALF_LAST);
    assign w_gapDone   = (r_tick == GAP_LAST);

    // Half-period phases: 0 lead-in high, odd phases low, even phases high, 33 tail high.
    // r_rx keeps only the last 12 bits shifted in, so MISO bits [15:12] fall off the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= 2'd0;
            r_tick     <= 16'd0;
            r_phase    <= 6'd0;
            r_txShift  <= 16'd0;
            r_rx       <= 12'd0;
            r_ssN      <= 1'b1;
            r_sclk     <= 1'b1;
            r_mosi     <= 1'b0;
            r_busy     <= 1'b0;
            r_cnvCmplt <= 1'b0;
            r_batt     <= 12'd0;
            r_irRght   <= 12'd0;
            r_irLft    <= 12'd0;
            r_irCntr   <= 12'd0;
        end else begin
            r_cnvCmplt <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (strt && !r_cnvCmplt) begin
                        r_busy    <= 1'b1;
                        r_idx     <= 2'd0;
                        r_state   <= S_TX1;
                        r_ssN     <= 1'b0;
                        r_mosi    <= w_cmd[15];
                        r_txShift <= {w_cmd[14:0], 1'b0};
                        r_tick    <= 16'd0;
                        r_phase   <= 6'd0;
                    end
                end
                S_TX1, S_TX2: begin
                    if (w_tickDone) begin
                        r_tick <= 16'd0;
                        if (r_phase == LAST_PHASE) begin
                            r_ssN   <= 1'b1;
                            r_state <= (r_state == S_TX1) ? S_GAP1 : S_WR;
                        end else begin
                            r_phase <= w_nextPhase;
                            if (w_nextPhase != LAST_PHASE) begin
                                if (w_nextPhase[0]) begin
                                    r_sclk <= 1'b0;
                                    if (w_nextPhase != 6'd1) begin
                                        r_mosi    <= r_txShift[15];
                                        r_txShift <= {r_txShift[14:0], 1'b0};
                                    end
                                end else begin
                                    r_sclk <= 1'b1;
                                    r_rx   <= {r_rx[10:0], spi.MISO};
                                end
                            end
                        end
                    end else begin
                        r_tick <= r_tick + 16'd1;
                    end
                end
                S_GAP1, S_GAP2: begin
                    if (w_gapDone) begin
                        r_state   <= (r_state == S_GAP1) ? S_TX2 : S_TX1;
                        r_ssN     <= 1'b0;
                        r_mosi    <= w_cmd[15];
                        r_txShift <= {w_cmd[14:0], 1'b0};
                        r_tick    <= 16'd0;
                        r_phase   <= 6'd0;
                    end else begin
                        r_tick <= r_tick + 16'd1;
                    end
                end
                S_WR: begin
                    case (r_idx)
                        2'd0:    r_batt   <= r_rx;
                        2'd1:    r_irRght <= r_rx;
                        2'd2:    r_irLft  <= r_rx;
                        default: r_irCntr <= r_rx;
                    endcase
                    r_tick <= 16'd0;
                    if (r_idx == 2'd3) begin
                        r_cnvCmplt <= 1'b1;
`ifdef A2D_CONTINUOUS_EN
                        r_idx   <= 2'd0;
                        r_state <= S_GAP2;
`else
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
`endif
                    end else begin
                        r_idx   <= r_idx + 2'd1;
                        r_state <= S_GAP2;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign spi.SS_n  = r_ssN;
    assign spi.SCLK  = r_sclk;
    assign spi.MOSI  = r_mosi;
    assign batt      = r_batt;
    assign IR_rght   = r_irRght;
    assign IR_lft    = r_irLft;
    assign IR_cntr   = r_irCntr;
    assign busy      = r_busy;
    assign cnv_cmplt = r_cnvCmplt;

endmodule

// File: tb/tb_a2d_rr_master.sv
// Testbench for a2d_rr_master with a behavioural ADC128S model on the SPI bus.
// Define A2D_CONTINUOUS_EN to run the continuous-conversion scenario instead.
`timescale 1ns/1ps
module tb_a2d_rr_master;

    localparam int SCLK_DIV   = 32;
    localparam int GAP_CYCLES = 8;
    localparam int PERIOD     = 10;

    logic        clk  = 1'b0;
    logic        rst  = 1'b0;
    logic        strt = 1'b0;
    logic [11:0] batt;
    logic [11:0] irRght;
    logic [11:0] irLft;
    logic [11:0] irCntr;
    logic        busy;
    logic        cnvCmplt;

    a2d_rr_master_if spiBus();

    a2d_rr_master #(.SCLK_DIV(SCLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk       (clk),
        .rst       (rst),
        .strt      (strt),
        .spi       (spiBus),
        .batt      (batt),
        .IR_rght   (irRght),
        .IR_lft    (irLft),
        .IR_cntr   (irCntr),
        .busy      (busy),
        .cnv_cmplt (cnvCmplt)
    );

    always #(PERIOD / 2) clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cmpltCnt = 0;

    logic [11:0] chanVal [8] = '{default: 12'h000};
    logic [2:0]  chList  [4] = '{3'd0, 3'd2, 3'd5, 3'd7};
    logic [2:0]  prevCh = 3'd0;
    logic [15:0] resp = 16'h0;
    logic [15:0] mosiWord = 16'h0;
    logic        lastSs = 1'bx;
    logic        lastSclk = 1'bx;
    int          fallCnt = 0;
    bit          inTx = 1'b0;
    bit          haveRise = 1'b0;
    time         fallTime = 0;
    time         riseTime = 0;
    logic [15:0] mosiQ [$];
    int          lowQ [$];
    int          gapQ [$];
    int          fallQ [$];

    // ADC128S model: the word returned in a frame is the conversion addressed by the previous frame
    always @(spiBus.SS_n or spiBus.SCLK) begin
        if (spiBus.SS_n === 1'b0 && lastSs === 1'b1) begin
            inTx        = 1'b1;
            fallCnt     = 0;
            mosiWord    = 16'h0;
            resp        = {4'($urandom), chanVal[prevCh]};
            spiBus.MISO = resp[15];
            if (haveRise) gapQ.push_back(int'(($time - riseTime) / PERIOD));
            fallTime    = $time;
        end else if (spiBus.SS_n === 1'b1 && lastSs === 1'b0 && inTx) begin
            inTx     = 1'b0;
            mosiQ.push_back(mosiWord);
            lowQ.push_back(int'(($time - fallTime) / PERIOD));
            fallQ.push_back(fallCnt);
            prevCh   = mosiWord[13:11];
            riseTime = $time;
            haveRise = 1'b1;
        end
        if (inTx && spiBus.SS_n === 1'b0) begin
            if (spiBus.SCLK === 1'b0 && lastSclk === 1'b1) begin
                if (fallCnt < 16) spiBus.MISO = resp[4'(15 - fallCnt)];
                fallCnt++;
            end
            if (spiBus.SCLK === 1'b1 && lastSclk === 1'b0)
                mosiWord = {mosiWord[14:0], spiBus.MOSI};
        end
        lastSs   = spiBus.SS_n;
        lastSclk = spiBus.SCLK;
    end

    always @(negedge clk) if (cnvCmplt === 1'b1) cmpltCnt++;

    task automatic pulse_strt;
        @(negedge clk) strt = 1'b1;
        @(negedge clk) strt = 1'b0;
    endtask

    task automatic wait_cmplt(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cnvCmplt === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (spiBus.SS_n !== 1'b1) $display("[TB] FAIL reset SS_n: got %b want 1", spiBus.SS_n); else passes++;
        checks++; if (spiBus.SCLK !== 1'b1) $display("[TB] FAIL reset SCLK: got %b want 1", spiBus.SCLK); else passes++;
        checks++; if (spiBus.MOSI !== 1'b0) $display("[TB] FAIL reset MOSI: got %b want 0", spiBus.MOSI); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset busy: got %b want 0", busy); else passes++;
        checks++; if (cnvCmplt !== 1'b0) $display("[TB] FAIL reset cnv_cmplt: got %b want 0", cnvCmplt); else passes++;
        checks++;
        if ({batt, irRght, irLft, irCntr} !== 48'h0)
            $display("[TB] FAIL reset results: got %h %h %h %h want all 000", batt, irRght, irLft, irCntr);
        else passes++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_round(input logic [11:0] v0, input logic [11:0] v2,
                              input logic [11:0] v5, input logic [11:0] v7, input string tag);
        bit ok;
        int startCnt;
        int bad;
        int n;
        logic [15:0] expCmd;
        chanVal[0] = v0; chanVal[2] = v2; chanVal[5] = v5; chanVal[7] = v7;
        mosiQ.delete(); lowQ.delete(); gapQ.delete(); fallQ.delete();
        startCnt = cmpltCnt;
        pulse_strt();
        checks++; if (busy !== 1'b1) $display("[TB] FAIL %s busy after strt: got %b want 1", tag, busy); else passes++;
        wait_cmplt(6000, ok);
        checks++;
        if (!ok) begin
            $display("[TB] FAIL %s cnv_cmplt timeout: got none want pulse within 6000 cycles", tag);
            return;
        end
        passes++;
        checks++; if (batt !== v0) $display("[TB] FAIL %s batt: got %h want %h", tag, batt, v0); else passes++;
        checks++; if (irRght !== v2) $display("[TB] FAIL %s IR_rght: got %h want %h", tag, irRght, v2); else passes++;
        checks++; if (irLft !== v5) $display("[TB] FAIL %s IR_lft: got %h want %h", tag, irLft, v5); else passes++;
        checks++; if (irCntr !== v7) $display("[TB] FAIL %s IR_cntr: got %h want %h", tag, irCntr, v7); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL %s busy at cnv_cmplt: got %b want 0", tag, busy); else passes++;
        repeat (20) @(negedge clk);
        checks++;
        if (cmpltCnt - startCnt != 1) $display("[TB] FAIL %s cnv_cmplt pulses: got %0d want 1", tag, cmpltCnt - startCnt);
        else passes++;
        bad = (mosiQ.size() == 8) ? 0 : 1;
        for (int i = 0; i < mosiQ.size() && i < 8; i++) begin
            expCmd = {2'b00, chList[i / 2], 11'h000};
            if (mosiQ[i] !== expCmd) begin
                $display("[TB] FAIL %s MOSI word %0d: got %h want %h", tag, i, mosiQ[i], expCmd);
                bad++;
            end
        end
        checks++;
        if (bad != 0) $display("[TB] FAIL %s MOSI frames: got %0d frames %0d bad want 8 frames 0 bad", tag, mosiQ.size(), bad);
        else passes++;
        bad = 0;
        foreach (lowQ[i]) if (lowQ[i] != 17 * SCLK_DIV) bad++;
        checks++;
        if (bad != 0 || lowQ.size() != 8) $display("[TB] FAIL %s SS_n low width: got %0d bad of %0d want all %0d", tag, bad, lowQ.size(), 17 * SCLK_DIV);
        else passes++;
        bad = 0;
        foreach (fallQ[i]) if (fallQ[i] != 16) bad++;
        checks++;
        if (bad != 0 || fallQ.size() != 8) $display("[TB] FAIL %s SCLK falls: got %0d bad of %0d frames want 16 each", tag, bad, fallQ.size());
        else passes++;
        n = gapQ.size();
        bad = (n >= 7) ? 0 : 1;
        if (n >= 7) for (int k = 0; k < 4; k++) if (gapQ[n - 7 + 2 * k] != GAP_CYCLES) bad++;
        checks++;
        if (bad != 0) $display("[TB] FAIL %s SS_n gap TX1-TX2: got %0d bad of %0d gaps want %0d", tag, bad, n, GAP_CYCLES);
        else passes++;
    endtask

    task automatic test_random_rounds;
        for (int r = 0; r < 3; r++)
            test_round(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom), "random");
        test_round(12'hFFF, 12'h000, 12'hFFF, 12'h000, "extremes");
    endtask

    task automatic test_strt_while_busy;
        bit ok;
        int startCnt;
        startCnt = cmpltCnt;
        pulse_strt();
        repeat (590) @(negedge clk);
        pulse_strt();
        wait_cmplt(6000, ok);
        checks++; if (!ok) $display("[TB] FAIL busy_strt cnv_cmplt: got none want pulse"); else passes++;
        repeat (50) @(negedge clk);
        checks++; if (busy !== 1'b0) $display("[TB] FAIL busy_strt queued round: got busy %b want 0", busy); else passes++;
        repeat (1000) @(negedge clk);
        checks++;
        if (cmpltCnt - startCnt != 1) $display("[TB] FAIL busy_strt pulses: got %0d want 1", cmpltCnt - startCnt);
        else passes++;
    endtask

    task automatic test_strt_at_cmplt;
        bit ok;
        pulse_strt();
        wait_cmplt(6000, ok);
        checks++; if (!ok) $display("[TB] FAIL cmplt_strt first round: got no cnv_cmplt want pulse"); else passes++;
        strt = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("[TB] FAIL cmplt_strt same-cycle strt: got busy %b want 0", busy); else passes++;
        @(negedge clk);
        strt = 1'b0;
        checks++; if (busy !== 1'b1) $display("[TB] FAIL cmplt_strt next-cycle strt: got busy %b want 1", busy); else passes++;
        wait_cmplt(6000, ok);
        checks++; if (!ok) $display("[TB] FAIL cmplt_strt second round: got no cnv_cmplt want pulse"); else passes++;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int startCnt;
        startCnt = cmpltCnt;
        pulse_strt();
        repeat (1500) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (spiBus.SS_n !== 1'b1) $display("[TB] FAIL mid_reset SS_n: got %b want 1", spiBus.SS_n); else passes++;
        checks++; if (spiBus.SCLK !== 1'b1) $display("[TB] FAIL mid_reset SCLK: got %b want 1", spiBus.SCLK); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL mid_reset busy: got %b want 0", busy); else passes++;
        checks++;
        if ({batt, irRght, irLft, irCntr} !== 48'h0)
            $display("[TB] FAIL mid_reset results: got %h %h %h %h want all 000", batt, irRght, irLft, irCntr);
        else passes++;
        rst = 1'b0;
        repeat (5000) @(negedge clk);
        checks++;
        if (cmpltCnt != startCnt) $display("[TB] FAIL mid_reset pulses: got %0d want 0", cmpltCnt - startCnt);
        else passes++;
        checks++;
        if ({batt, irRght, irLft, irCntr} !== 48'h0)
            $display("[TB] FAIL mid_reset results later: got %h %h %h %h want all 000", batt, irRght, irLft, irCntr);
        else passes++;
    endtask

    task automatic test_continuous;
        bit ok;
        chanVal[0] = 12'hA5A; chanVal[2] = 12'h123; chanVal[5] = 12'h456; chanVal[7] = 12'h789;
        pulse_strt();
        for (int r = 0; r < 2; r++) begin
            wait_cmplt(6000, ok);
            checks++; if (!ok) $display("[TB] FAIL continuous pulse %0d: got none want pulse", r); else passes++;
        end
        checks++; if (busy !== 1'b1) $display("[TB] FAIL continuous busy: got %b want 1", busy); else passes++;
        checks++;
        if ({batt, irRght, irLft, irCntr} !== {12'hA5A, 12'h123, 12'h456, 12'h789})
            $display("[TB] FAIL continuous results: got %h %h %h %h want a5a 123 456 789", batt, irRght, irLft, irCntr);
        else passes++;
        chanVal[5] = 12'h0FF;
        for (int r = 0; r < 2; r++) begin
            wait_cmplt(6000, ok);
            checks++; if (!ok) $display("[TB] FAIL continuous later pulse %0d: got none want pulse", r); else passes++;
        end
        checks++; if (irLft !== 12'h0FF) $display("[TB] FAIL continuous IR_lft update: got %h want 0ff", irLft); else passes++;
        checks++; if (busy !== 1'b1) $display("[TB] FAIL continuous busy later: got %b want 1", busy); else passes++;
    endtask

    initial begin
        spiBus.MISO = 1'b0;
        test_reset();
`ifdef A2D_CONTINUOUS_EN
        test_continuous();
`else
        test_round(12'hA5A, 12'h123, 12'h456, 12'h789, "directed");
        test_random_rounds();
        test_strt_while_busy();
        test_strt_at_cmplt();
        test_reset_mid();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
